// File: rtl/mem_fill_arbiter_if.sv
// Cache-side and memory-side signal bundle for mem_fill_arbiter.
// slave: arbiter view.  master: cache controllers + memory model view.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8
);
  localparam int WORD_W = $clog2(WORDS_PER_BLK);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic              i_data_vld;
  logic [WORD_W-1:0] i_word;
  logic              i_done;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_grant;
  logic              d_data_vld;
  logic [WORD_W-1:0] d_word;
  logic              d_done;

  logic [DATA_W-1:0] fill_data;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvld;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvld,
    output i_grant, i_data_vld, i_word, i_done,
    output d_grant, d_data_vld, d_word, d_done,
    output fill_data, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvld,
    input  i_grant, i_data_vld, i_word, i_done,
    input  d_grant, d_data_vld, d_word, d_done,
    input  fill_data, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares a single-ported memory between I-cache block fills and D-cache
// block fills / write-through stores. Fills issue one word address per
// cycle and stream returned words to the owning side.
// Optional feature macro: ARB_RR_EN (round-robin on simultaneous requests;
// default build gives D fixed priority over I).
module mem_fill_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8
) (
  input logic               clk,
  input logic               rst_n,
  mem_fill_arbiter_if.slave bus
);
  localparam int WORD_W = $clog2(WORDS_PER_BLK);
  localparam int OFF_W  = WORD_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t            state;
  logic [WORD_W:0]   iss_cnt;
  logic [WORD_W-1:0] ret_cnt;
  logic [ADDR_W-1:0] base;
  logic              i_grant_r;
  logic              d_grant_r;
  logic              wr_done_r;
  logic              mem_en_r;
  logic              mem_wr_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic              prio_d;
  logic              take_d;
  logic              take_i;
  logic              last_word;
  logic [OFF_W-1:0]  iss_off;

`ifdef ARB_RR_EN
  logic last_d;

  // Remember which side was granted last so contention alternates
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_d <= 1'b0;
    else if (state == IDLE && (take_d || take_i))
      last_d <= take_d;
  end

  // Favour the side not served last
  always_comb prio_d = ~last_d;
`else
  // Fixed D-over-I priority
  always_comb prio_d = 1'b1;
`endif

  // Request selection and in-block offset of the next issued word
  always_comb begin
    take_d    = bus.d_req & (~bus.i_req | prio_d);
    take_i    = bus.i_req & ~take_d;
    last_word = (ret_cnt == WORD_W'(WORDS_PER_BLK - 1));
    iss_off   = {iss_cnt[WORD_W-1:0], 1'b0};
  end

  // Arbitration FSM with registered grant and memory-command outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      iss_cnt     <= '0;
      ret_cnt     <= '0;
      base        <= '0;
      i_grant_r   <= 1'b0;
      d_grant_r   <= 1'b0;
      wr_done_r   <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      i_grant_r   <= 1'b0;
      d_grant_r   <= 1'b0;
      wr_done_r   <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_wdata_r <= '0;
      case (state)
        IDLE: begin
          mem_en_r <= 1'b0;
          // First word is issued in the grant cycle, so the entry edge
          // already loads word 0 and pre-counts it in iss_cnt.
          if (take_d && bus.d_wr) begin
            state       <= D_WRITE;
            d_grant_r   <= 1'b1;
            wr_done_r   <= 1'b1;
            mem_en_r    <= 1'b1;
            mem_wr_r    <= 1'b1;
            mem_addr_r  <= bus.d_addr;
            mem_wdata_r <= bus.d_wdata;
          end else if (take_d) begin
            state      <= D_FILL;
            d_grant_r  <= 1'b1;
            base       <= bus.d_addr & BLK_MASK;
            mem_en_r   <= 1'b1;
            mem_addr_r <= bus.d_addr & BLK_MASK;
            iss_cnt    <= (WORD_W + 1)'(1);
          end else if (take_i) begin
            state      <= I_FILL;
            i_grant_r  <= 1'b1;
            base       <= bus.i_addr & BLK_MASK;
            mem_en_r   <= 1'b1;
            mem_addr_r <= bus.i_addr & BLK_MASK;
            iss_cnt    <= (WORD_W + 1)'(1);
          end
        end
        I_FILL, D_FILL: begin
          if (iss_cnt != (WORD_W + 1)'(WORDS_PER_BLK)) begin
            mem_en_r   <= 1'b1;
            mem_addr_r <= base | ADDR_W'(iss_off);
            iss_cnt    <= iss_cnt + (WORD_W + 1)'(1);
          end else begin
            mem_en_r <= 1'b0;
          end
          if (bus.mem_rvld) begin
            if (last_word) begin
              state    <= IDLE;
              iss_cnt  <= '0;
              ret_cnt  <= '0;
              mem_en_r <= 1'b0;
            end else begin
              ret_cnt <= ret_cnt + WORD_W'(1);
            end
          end
        end
        D_WRITE: begin
          state    <= IDLE;
          mem_en_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path follows mem_rvld in the same cycle; masked during reset
  always_comb begin
    bus.i_data_vld = rst_n & (state == I_FILL) & bus.mem_rvld;
    bus.d_data_vld = rst_n & (state == D_FILL) & bus.mem_rvld;
    bus.i_word     = bus.i_data_vld ? ret_cnt : '0;
    bus.d_word     = bus.d_data_vld ? ret_cnt : '0;
    bus.i_done     = bus.i_data_vld & last_word;
    bus.d_done     = wr_done_r | (bus.d_data_vld & last_word);
    bus.i_grant    = i_grant_r;
    bus.d_grant    = d_grant_r;
    bus.fill_data  = bus.mem_rdata;
    bus.mem_en     = mem_en_r;
    bus.mem_wr     = mem_wr_r;
    bus.mem_addr   = mem_addr_r;
    bus.mem_wdata  = mem_wdata_r;
  end
endmodule
